key_schedule_engine: RTL and testbench

- Iterative AES key-schedule engine for AES-128, AES-192 and AES-256; the key length is selected per operation.
- Loads a cipher key, then generates one 32-bit schedule word per clock using a single shared subByte instance and the rcon table.
- Stores the full schedule internally.
- Serves round keys to the cipher datapath through a registered read port, so cipher rounds no longer need one expansion stage each.

---
 rtl/key_schedule_if.sv | 24 ++
 rtl/key_schedule_engine.sv | 178 +++++++++++++++++
 tb/tb_key_schedule_engine.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_if.sv
// Handshake and round-key read bus between the cipher control and the AES key-schedule engine.
interface key_schedule_if #(
    parameter int unsigned MAX_NK = 8
);
    logic                    start;
    logic [1:0]              keySize;
    logic [32*MAX_NK-1:0]    keyIn;
    logic                    busy;
    logic                    done;
    logic                    keyValid;
    logic                    error;
    logic [3:0]              rkAddr;
    logic [127:0]            rkData;

    modport master (
        output start, keySize, keyIn, rkAddr,
        input  busy, done, keyValid, error, rkData
    );

    modport slave (
        input  start, keySize, keyIn, rkAddr,
        output busy, done, keyValid, error, rkData
    );
endinterface

// File: rtl/key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock, full schedule stored,
// round keys served through a read port.
module key_schedule_engine #(
    parameter int unsigned MAX_NK     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    key_schedule_if.slave  bus
);
    localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
    localparam int unsigned AW    = $clog2(DEPTH);

    if (!(MAX_NK == 4 || MAX_NK == 6 || MAX_NK == 8)) begin : g_bad_max_nk
        $error("key_schedule_engine: MAX_NK must be 4, 6 or 8");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state;
    logic [31:0]     w [DEPTH];
    logic [3:0]      nk_q, nr_q, kcnt_q, rcon_idx_q;
    logic [AW-1:0]   i_q, last_q;
    logic            busy_q, done_q, valid_q, error_q;

    logic [3:0]      req_nk;
    logic            legal;
    logic            rot_sel, sub_sel;
    logic [31:0]     prev_word, back_word, sub_out, temp, new_word;
    logic [AW-1:0]   rd_base;
    logic            rd_ok;
    logic [127:0]    rd_word;

    // Start decode: requested key length and whether this build can hold it.
    always_comb begin
        case (bus.keySize)
            2'b00:   req_nk = 4'd4;
            2'b01:   req_nk = 4'd6;
            2'b10:   req_nk = 4'd8;
            default: req_nk = 4'd0;
        endcase
        legal = (req_nk != 4'd0) && (req_nk <= 4'(MAX_NK));
    end

    // Next schedule word; the single SubWord unit is shared by both substitution cases.
    always_comb begin
        prev_word = w[i_q - AW'(1)];
        back_word = w[i_q - AW'(nk_q)];
        rot_sel   = (kcnt_q == 4'd0);
        sub_sel   = (nk_q == 4'd8) && (kcnt_q == 4'd4);
        sub_out   = sub_word(rot_sel ? {prev_word[23:0], prev_word[31:24]} : prev_word);
        if (rot_sel)
            temp = sub_out ^ {rcon(rcon_idx_q), 24'h0};
        else if (sub_sel)
            temp = sub_out;
        else
            temp = prev_word;
        new_word = back_word ^ temp;
    end

    // Schedule storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && reset && bus.start && legal) begin
            for (int unsigned k = 0; k < MAX_NK; k++) begin
                if (k < 32'(req_nk))
                    w[AW'(k)] <= bus.keyIn[32*(MAX_NK-k)-1 -: 32];
            end
        end else if (state == EXPAND) begin
            w[i_q] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            nk_q       <= 4'd4;
            nr_q       <= 4'd10;
            last_q     <= '0;
            i_q        <= '0;
            kcnt_q     <= 4'd0;
            rcon_idx_q <= 4'd1;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (legal) begin
                            nk_q       <= req_nk;
                            nr_q       <= req_nk + 4'd6;
                            last_q     <= AW'({req_nk, 2'b00} + 6'd27);
                            i_q        <= AW'(req_nk);
                            kcnt_q     <= 4'd0;
                            rcon_idx_q <= 4'd1;
                            busy_q     <= 1'b1;
                            valid_q    <= 1'b0;
                            state      <= EXPAND;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    i_q    <= i_q + AW'(1);
                    kcnt_q <= (kcnt_q == nk_q - 4'd1) ? 4'd0 : kcnt_q + 4'd1;
                    if (rot_sel)
                        rcon_idx_q <= rcon_idx_q + 4'd1;
                    if (i_q == last_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Round-key read: zero outside the latched schedule or when nothing has been loaded.
    always_comb begin
        rd_base = AW'({bus.rkAddr, 2'b00});
        rd_ok   = (bus.rkAddr <= nr_q) && (valid_q || busy_q);
        rd_word = rd_ok ? {w[rd_base], w[rd_base + AW'(1)], w[rd_base + AW'(2)], w[rd_base + AW'(3)]}
                        : 128'h0;
    end

    if (RD_LATENCY == 0) begin : g_rd_comb
        assign bus.rkData = rd_word;
    end else begin : g_rd_reg
        logic [127:0] rk_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rk_q <= 128'h0;
            else        rk_q <= rd_word;
        end
        assign bus.rkData = rk_q;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.keyValid = valid_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_key_schedule_engine.sv
// Self-checking bench for key_schedule_engine against a FIPS-197 style reference expansion
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_key_schedule_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_schedule_if #(.MAX_NK(8)) bus8 ();
    key_schedule_if #(.MAX_NK(6)) bus6 ();

    key_schedule_engine #(.MAX_NK(8), .RD_LATENCY(1)) dut  (.clk(clk), .reset(reset), .bus(bus8));
    key_schedule_engine #(.MAX_NK(6), .RD_LATENCY(1)) dut6 (.clk(clk), .reset(reset), .bus(bus6));

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0]  sbox_m [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = (b == 0) ? 8'h00 : 8'h01;
            if (b != 0) repeat (254) inv = gmul(inv, 8'(b));
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word_m(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] ks, input logic [255:0] key);
        bus8.keySize = ks;
        bus8.keyIn   = key;
        bus8.start   = 1'b1;
        tick();
        bus8.start   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus8.done && n < 200);
    endtask

    task automatic read_rk(input int r, output logic [127:0] d);
        bus8.rkAddr = 4'(r);
        tick();
        d = bus8.rkData;
    endtask

    task automatic check_schedule(input int nk, input string tag);
        logic [127:0] d, e;
        for (int r = 0; r < 16; r++) begin
            read_rk(r, d);
            e = (r <= nk + 6) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0;
            n_tests++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL %s rk[%0d]: got %h expected %h", tag, r, d, e);
            end
        end
    endtask

    task automatic run_and_check(input logic [1:0] ks, input logic [255:0] key, input string tag);
        int n, nk;
        nk = 4 + 2 * int'(ks);
        start_op(ks, key);
        n_tests++;
        if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", tag, bus8.busy); end
        wait_done(n);
        n_tests++;
        if (n != 4 * (nk + 7) - nk) begin n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", tag, n, 4*(nk+7)-nk); end
        n_tests++;
        if (bus8.keyValid !== 1'b1 || bus8.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s valid_at_done: got valid=%b busy=%b expected 1/0", tag, bus8.keyValid, bus8.busy);
        end
        tick();
        n_tests++;
        if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL %s done_one_cycle: got %b expected 0", tag, bus8.done); end
        model_expand(key, nk);
        check_schedule(nk, tag);
    endtask

    task automatic check_rk(input int r, input logic [127:0] e, input string tag);
        logic [127:0] d;
        read_rk(r, d);
        n_tests++;
        if (d !== e) begin n_fail++; $display("FAIL %s rk[%0d]: got %h expected %h", tag, r, d, e); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus8.start = 1'b0; bus8.keySize = 2'b00; bus8.keyIn = '0; bus8.rkAddr = 4'd0;
        bus6.start = 1'b0; bus6.keySize = 2'b00; bus6.keyIn = '0; bus6.rkAddr = 4'd0;
        repeat (3) tick();
        n_tests++;
        if ({bus8.busy, bus8.done, bus8.keyValid, bus8.error} !== 4'b0000 || bus8.rkData !== 128'h0) begin
            n_fail++; $display("FAIL reset_state: got flags=%b rk=%h expected 0000/0",
                               {bus8.busy, bus8.done, bus8.keyValid, bus8.error}, bus8.rkData);
        end
        reset = 1'b1;
        tick();
        check_rk(0, 128'h0, "idle_unloaded");
    endtask

    task automatic test_vectors();
        run_and_check(2'b00, KEY128, "aes128");
        check_rk(1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_vec");
        check_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_vec");
        check_rk(11, 128'h0, "aes128_vec");
        run_and_check(2'b01, KEY192, "aes192");
        check_rk(12, 128'he98ba06f448c773c8ecc720401002202, "aes192_vec");
        run_and_check(2'b10, KEY256, "aes256");
        check_rk(14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_vec");
    endtask

    task automatic test_random();
        logic [255:0] key;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom;
            run_and_check(2'($urandom_range(0, 2)), key, "random");
        end
    endtask

    task automatic test_errors();
        int n;
        start_op(2'b11, KEY256);
        n_tests++;
        if (bus8.error !== 1'b1 || bus8.busy !== 1'b0 || bus8.keyValid !== 1'b1) begin
            n_fail++; $display("FAIL illegal_size: got err=%b busy=%b valid=%b expected 1/0/1",
                               bus8.error, bus8.busy, bus8.keyValid);
        end
        tick();
        n_tests++;
        if (bus8.error !== 1'b0) begin n_fail++; $display("FAIL error_one_cycle: got %b expected 0", bus8.error); end
        bus6.keySize = 2'b10; bus6.keyIn = KEY192[255:64]; bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        n_tests++;
        if (bus6.error !== 1'b1 || bus6.busy !== 1'b0 || bus6.keyValid !== 1'b0) begin
            n_fail++; $display("FAIL nk_too_big: got err=%b busy=%b valid=%b expected 1/0/0",
                               bus6.error, bus6.busy, bus6.keyValid);
        end
        bus6.keySize = 2'b01; bus6.start = 1'b1;
        tick();
        bus6.start = 1'b0;
        n_tests++;
        if (bus6.error !== 1'b0 || bus6.busy !== 1'b1) begin
            n_fail++; $display("FAIL nk6_accept: got err=%b busy=%b expected 0/1", bus6.error, bus6.busy);
        end
        n = 0;
        do begin tick(); n++; end while (!bus6.done && n < 200);
        n_tests++;
        if (n != 46) begin n_fail++; $display("FAIL nk6_done_latency: got %0d expected 46", n); end
        bus6.rkAddr = 4'd12;
        tick();
        n_tests++;
        if (bus6.rkData !== 128'he98ba06f448c773c8ecc720401002202) begin
            n_fail++; $display("FAIL nk6_rk12: got %h expected e98ba06f448c773c8ecc720401002202", bus6.rkData);
        end
    endtask

    task automatic test_busy_start();
        int n;
        start_op(2'b00, KEY128);
        repeat (19) tick();
        bus8.keySize = 2'b10; bus8.keyIn = {$urandom, $urandom, $urandom, $urandom, 128'h1}; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        n_tests++;
        if (bus8.error !== 1'b0 || bus8.busy !== 1'b1) begin
            n_fail++; $display("FAIL start_while_busy: got err=%b busy=%b expected 0/1", bus8.error, bus8.busy);
        end
        wait_done(n);
        n_tests++;
        if (n != 20) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 20", n); end
        check_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "busy_start");
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(2'b00, KEY128);
        wait_done(n);
        start_op(2'b10, KEY256);
        n_tests++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus8.keyValid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b valid=%b expected 1/0/0",
                               bus8.busy, bus8.done, bus8.keyValid);
        end
        wait_done(n);
        n_tests++;
        if (n != 52) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 52", n); end
        model_expand(KEY256, 8);
        check_schedule(8, "b2b");
    endtask

    task automatic test_reset_mid();
        start_op(2'b00, KEY128);
        bus8.rkAddr = 4'd0;
        repeat (14) tick();
        #3;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus8.busy, bus8.done, bus8.keyValid} !== 3'b000 || bus8.rkData !== 128'h0) begin
            n_fail++; $display("FAIL reset_mid: got flags=%b rk=%h expected 000/0",
                               {bus8.busy, bus8.done, bus8.keyValid}, bus8.rkData);
        end
        #2;
        reset = 1'b1;
        tick();
        run_and_check(2'b00, KEY128, "rerun128");
        check_rk(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rerun128_vec");
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vectors();
        test_random();
        test_errors();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
